// File: rtl/sprite_blit_reader.sv
// Sprite read-side blitter: fetches SPR_W x SPR_H pixels from a 1-cycle RAM and streams them with screen coordinates.
// Optional build macro SPRITE_BLIT_KEY_SKIP_EN drops KEY_COLOR pixels instead of presenting them.
//
// state   | meaning
// IDLE    | waiting for start
// ISSUE   | read_address stable, RAM samples it at the closing edge
// LOAD    | mem_data valid, captured with coordinates
// PRESENT | pixel offered, held until pix_ready
// DONE    | one-cycle completion pulse
module sprite_blit_reader #(
    parameter int                SPR_W     = 40,
    parameter int                SPR_H     = 40,
    parameter int                ADDR_W    = 19,
    parameter int                DATA_W    = 24,
    parameter logic [DATA_W-1:0] KEY_COLOR = 24'hFF00FF
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [9:0]        dst_x,
    input  logic [9:0]        dst_y,
    output logic [ADDR_W-1:0] read_address,
    input  logic [DATA_W-1:0] mem_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [9:0]        pix_x,
    output logic [9:0]        pix_y,
    output logic [DATA_W-1:0] pix_color,
    output logic              busy,
    output logic              done
);

    localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

`ifdef SPRITE_BLIT_KEY_SKIP_EN
    localparam logic KEY_SKIP = 1'b1;
`else
    localparam logic KEY_SKIP = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_LOAD,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] base_r;
    logic [9:0]        dx_r, dy_r;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic              last_pix, end_of_row, key_hit, advance, load_pix;

    always_comb begin
        state_nxt  = state;
        end_of_row = (col == CW'(SPR_W - 1));
        last_pix   = end_of_row && (row == RW'(SPR_H - 1));
        key_hit    = KEY_SKIP && (mem_data == KEY_COLOR);
        advance    = 1'b0;
        load_pix   = 1'b0;
        case (state)
            S_IDLE:  if (start) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_LOAD;
            S_LOAD: begin
                if (key_hit) begin
                    // Skipped pixel behaves like an instant handshake.
                    advance   = !last_pix;
                    state_nxt = last_pix ? S_DONE : S_ISSUE;
                end else begin
                    load_pix  = 1'b1;
                    state_nxt = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (pix_ready) begin
                    advance   = !last_pix;
                    state_nxt = last_pix ? S_DONE : S_ISSUE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state     <= S_IDLE;
            base_r    <= '0;
            dx_r      <= '0;
            dy_r      <= '0;
            col       <= '0;
            row       <= '0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_color <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && start) begin
                base_r <= base_addr;
                dx_r   <= dst_x;
                dy_r   <= dst_y;
                col    <= '0;
                row    <= '0;
            end else if (state == S_DONE) begin
                col <= '0;
                row <= '0;
            end else if (advance) begin
                if (end_of_row) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            if (load_pix) begin
                pix_color <= mem_data;
                pix_x     <= dx_r + 10'(col);
                pix_y     <= dy_r + 10'(row);
            end
        end
    end

    assign read_address = base_r + ADDR_W'(row) * ADDR_W'(SPR_W) + ADDR_W'(col);
    assign pix_valid    = (state == S_PRESENT);
    assign busy         = (state != S_IDLE);
    assign done         = (state == S_DONE);

endmodule

// File: doc/sprite_blit_reader.md
# sprite_blit_reader

Reads one sprite image out of a sprite memory (a frame RAM with a one-cycle synchronous read) and streams it pixel by pixel, in raster order, to a downstream consumer. Each pixel carries destination screen coordinates. The block sits between the sprite RAM read port and the framebuffer/line-buffer writer. It is the read-side engine for sprite data preloaded at the RAM write side.

## Interface
Parameters:
- SPR_W, 40: sprite width in pixels.
- SPR_H, 40: sprite height in pixels.
- ADDR_W, 19: sprite RAM address width.
- DATA_W, 24: pixel width (RGB 8:8:8).
- KEY_COLOR, 24'hFF00FF: transparent colour, used only when the key-skip feature is compiled in.

Ports:
- Clk  in  1  system clock; all logic is on the rising edge.
- Reset_n  in  1  synchronous, active-low reset.
- start  in  1  request to blit one sprite; sampled only in IDLE.
- base_addr  in  ADDR_W  sprite start address in RAM; latched on accepted start.
- dst_x  in  10  destination x of the sprite's top-left pixel; latched on accepted start.
- dst_y  in  10  destination y of the sprite's top-left pixel; latched on accepted start.
- read_address  out  ADDR_W  sprite RAM read address.
- mem_data  in  DATA_W  sprite RAM read data; valid one cycle after the address is sampled.
- pix_valid  out  1  pixel offered.
- pix_ready  in  1  consumer accepts the pixel.
- pix_x  out  10  screen x of the offered pixel.
- pix_y  out  10  screen y of the offered pixel.
- pix_color  out  DATA_W  colour of the offered pixel.
- busy  out  1  high from the cycle after an accepted start until DONE is left.
- done  out  1  one-cycle pulse when the last pixel has been handled.

## Operation
- Internal registers:
  - base_r, dx_r, dy_r latch the request.
  - col counts 0..SPR_W-1.
  - row counts 0..SPR_H-1.
- read_address = base_r + row*SPR_W + col, computed combinationally and truncated to ADDR_W (wraps modulo 2^ADDR_W).
- State machine:
  - IDLE: if start, latch inputs, clear col/row, go to ISSUE. Otherwise stay.
  - ISSUE: read_address is stable; the RAM samples it at the closing edge. Go to LOAD.
  - LOAD: mem_data is valid. Register it into pix_color. Register pix_x = dx_r+col and pix_y = dy_r+row, each modulo 2^10 with no clipping. Go to PRESENT.
  - PRESENT: pix_valid=1 and all pixel outputs are held stable. When pix_ready=1:
    - if col=SPR_W-1 and row=SPR_H-1, go to DONE;
    - otherwise advance: col+1, or col=0 and row+1 at end of row; go to ISSUE.
  - DONE: done=1 for this cycle; clear col and row; go to IDLE.
- pix_valid is never withdrawn before the handshake completes. pix_ready is ignored outside PRESENT.
- start outside IDLE is ignored; there is no queueing.
- SPR_W=1 and/or SPR_H=1 are legal. For a 1×1 sprite the sequence is ISSUE, LOAD, PRESENT, DONE.

## Timing
- Reset values: state IDLE; busy 0, done 0, pix_valid 0, pix_x 0, pix_y 0, pix_color 0; col 0, row 0, base_r 0, so read_address 0.
- Reset asserted mid-blit: at that edge return to IDLE with reset values. No done pulse is produced and the partial pixel is dropped.
- Start is accepted at edge T. ISSUE runs in cycle T+1, LOAD in T+2, and the first pix_valid is seen in cycle T+3.
- Per pixel cost is 3 cycles minimum (ISSUE, LOAD, PRESENT with ready already high), plus one cycle per stalled PRESENT cycle.
- With ready held high, an unkeyed full sprite takes 3·SPR_W·SPR_H cycles from ISSUE entry to DONE. done then rises one cycle after the last handshake edge.
- busy is 1 in ISSUE, LOAD, PRESENT and DONE.

## Configuration
- Macro: SPRITE_BLIT_KEY_SKIP_EN.
- Defined: in LOAD, if mem_data == KEY_COLOR the pixel is not presented. The counters advance exactly as on a handshake, and the next state is ISSUE, or DONE if this was the last pixel. pix_valid stays 0 for that pixel.
- Not defined: every pixel is presented, including KEY_COLOR pixels. KEY_COLOR is unused.

## Test plan
- Basic order: SPR_W=4, SPR_H=2, base=100, dst=(10,20), RAM[100..107]=1..8, ready always 1 → eight pixels with colours 1..8. Coordinates run (10,20)…(13,20), then (10,21)…(13,21). done pulses once, 24 cycles after ISSUE entry.
- Backpressure: same setup, ready low for 5 cycles on pixel 3 → pix_valid, pix_x, pix_y and pix_color stay constant throughout the stall. read_address stays at 102. No pixel is lost or duplicated.
- Wrap-around: base=2^19-2, SPR_W=4, SPR_H=1 → addresses 524286, 524287, 0, 1. dst_x=1022 → pix_x values 1022, 1023, 0, 1.
- Ignored start and reset: pulse start while busy → no effect on the stream. Assert Reset_n=0 in PRESENT of pixel 5 → next cycle IDLE, all outputs 0, no done pulse. A new start then completes normally.
- Key skip (macro defined): RAM=[1, FF00FF, 3, FF00FF] → only colours 1 and 3 are presented, at x offsets 0 and 2. done still pulses once. With the macro undefined, all four pixels are presented.
- Degenerate size: SPR_W=SPR_H=1, ready=1 → exactly one pixel, with pix_valid seen 3 cycles after start acceptance and done one cycle after the handshake.
